ring_code_monitor: RTL and testbench

//   Receive-side companion to the 4-bit ring counter. Samples a one-hot ring code each clock and decodes it to a binary index.

---
 rtl/ring_code_monitor_pkg.sv | 12 +
 rtl/ring_code_monitor_if.sv | 27 ++
 rtl/ring_code_monitor_onehot_to_bin.sv | 21 ++
 rtl/ring_code_monitor.sv | 128 ++++++++++++
 tb/tb_ring_code_monitor.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/ring_code_monitor_pkg.sv
// Shared definitions for the ring code monitor: FSM state encoding.
// Encoding ST_BAD is unreachable in normal operation and recovers to ST_IDLE.
package ring_code_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2,
    ST_BAD  = 2'd3
  } state_e;

endpackage

// File: rtl/ring_code_monitor_if.sv
// Sample/result bundle between a ring code source and the ring code monitor.
interface ring_code_monitor_if #(
  parameter int WIDTH = 4,
  parameter int IDXW  = 2,
  parameter int ERRW  = 8
);

  logic             in_valid;
  logic [WIDTH-1:0] ring_in;
  logic [IDXW-1:0]  index;
  logic             index_valid;
  logic             onehot_err;
  logic             seq_err;
  logic             locked;
  logic [ERRW-1:0]  err_count;

  modport master (
    output in_valid, ring_in,
    input  index, index_valid, onehot_err, seq_err, locked, err_count
  );

  modport slave (
    input  in_valid, ring_in,
    output index, index_valid, onehot_err, seq_err, locked, err_count
  );

endinterface

// File: rtl/ring_code_monitor_onehot_to_bin.sv
// Combinational one-hot decoder: flags whether exactly one bit is set and
// returns the position of the set bit (meaningful only when is_onehot=1).
module onehot_to_bin #(
  parameter int WIDTH = 4,
  parameter int IDXW  = 2
) (
  input  logic [WIDTH-1:0] in,
  output logic [IDXW-1:0]  idx,
  output logic             is_onehot
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in[i]) idx = idx | IDXW'(i);
    end
    // Non-zero with no second bit set: clearing the lowest set bit leaves zero.
    is_onehot = (in != '0) && ((in & (in - WIDTH'(1))) == '0);
  end

endmodule

// File: rtl/ring_code_monitor.sv
// Ring code checker/decoder: decodes each valid one-hot sample to an index,
// checks it is the rotate-left successor of the previous sample, tracks lock.
module ring_code_monitor
  import ring_code_monitor_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int IDXW     = 2,
  parameter int LOCK_CNT = 3,
  parameter int ERRW     = 8,
  parameter bit HOLD_OK  = 1'b0
) (
  input  logic              clk,
  input  logic              override,
  ring_code_monitor_if.slave bus
);

  localparam int RUNW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [RUNW-1:0] LOCK_RUN = RUNW'(LOCK_CNT);
  localparam logic [ERRW-1:0] ERR_MAX  = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [RUNW-1:0]  run_q, run_d;
  logic [IDXW-1:0]  index_q, index_d;
  logic             index_valid_q, index_valid_d;
  logic             onehot_err_q, onehot_err_d;
  logic             seq_err_q, seq_err_d;
  logic             locked_q, locked_d;
  logic [ERRW-1:0]  err_count_q, err_count_d;

  logic [IDXW-1:0]  dec_idx;
  logic             dec_onehot;
  logic [RUNW-1:0]  run_inc;

  onehot_to_bin #(
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) u_dec (
    .in        (bus.ring_in),
    .idx       (dec_idx),
    .is_onehot (dec_onehot)
  );

  function automatic logic [WIDTH-1:0] succ(input logic [WIDTH-1:0] p);
    return {p[WIDTH-2:0], p[WIDTH-1]};
  endfunction

  function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] c);
    return (c == ERR_MAX) ? c : c + ERRW'(1);
  endfunction

  assign run_inc = run_q + RUNW'(1);

  always_comb begin
    state_d       = (state_q == ST_BAD) ? ST_IDLE : state_q;
    prev_d        = prev_q;
    run_d         = run_q;
    index_d       = index_q;
    index_valid_d = 1'b0;
    onehot_err_d  = 1'b0;
    seq_err_d     = 1'b0;
    err_count_d   = err_count_q;

    if (bus.in_valid) begin
      if (!dec_onehot) begin
        onehot_err_d = 1'b1;
        state_d      = ST_IDLE;
      end else begin
        index_valid_d = 1'b1;
        index_d       = dec_idx;
        if (state_q == ST_ACQ || state_q == ST_LOCK) begin
          if (bus.ring_in == succ(prev_q)) begin
            prev_d = bus.ring_in;
            if (state_q == ST_ACQ) begin
              run_d = run_inc;
              if (run_inc == LOCK_RUN) state_d = ST_LOCK;
            end
          end else if (!(HOLD_OK && bus.ring_in == prev_q)) begin
            // Any other one-hot code restarts acquisition from this sample.
            seq_err_d = 1'b1;
            prev_d    = bus.ring_in;
            run_d     = '0;
            state_d   = ST_ACQ;
          end
        end else begin
          prev_d  = bus.ring_in;
          run_d   = '0;
          state_d = ST_ACQ;
        end
      end
      if (onehot_err_d || seq_err_d) err_count_d = sat_inc(err_count_q);
    end

    locked_d = (state_d == ST_LOCK);
  end

  always_ff @(posedge clk) begin
    if (override) begin
      state_q       <= ST_IDLE;
      prev_q        <= '0;
      run_q         <= '0;
      index_q       <= '0;
      index_valid_q <= 1'b0;
      onehot_err_q  <= 1'b0;
      seq_err_q     <= 1'b0;
      locked_q      <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      run_q         <= run_d;
      index_q       <= index_d;
      index_valid_q <= index_valid_d;
      onehot_err_q  <= onehot_err_d;
      seq_err_q     <= seq_err_d;
      locked_q      <= locked_d;
      err_count_q   <= err_count_d;
    end
  end

  assign bus.index       = index_q;
  assign bus.index_valid = index_valid_q;
  assign bus.onehot_err  = onehot_err_q;
  assign bus.seq_err     = seq_err_q;
  assign bus.locked      = locked_q;
  assign bus.err_count   = err_count_q;

endmodule

// File: tb/tb_ring_code_monitor.sv
// Bench for ring_code_monitor: three instances (default, HOLD_OK=1, ERRW=2) share
// one stimulus stream and are compared every cycle against a behavioural model.
module tb_ring_code_monitor;

  logic       clk = 1'b0;
  logic       ovr;
  logic       vld;
  logic [3:0] rin;

  always #5 clk = ~clk;

  ring_code_monitor_if #(.WIDTH(4), .IDXW(2), .ERRW(8)) if0 ();
  ring_code_monitor_if #(.WIDTH(4), .IDXW(2), .ERRW(8)) if1 ();
  ring_code_monitor_if #(.WIDTH(4), .IDXW(2), .ERRW(2)) if2 ();

  assign if0.in_valid = vld;
  assign if0.ring_in  = rin;
  assign if1.in_valid = vld;
  assign if1.ring_in  = rin;
  assign if2.in_valid = vld;
  assign if2.ring_in  = rin;

  ring_code_monitor #(.WIDTH(4), .IDXW(2), .LOCK_CNT(3), .ERRW(8), .HOLD_OK(1'b0))
    d0 (.clk(clk), .override(ovr), .bus(if0));
  ring_code_monitor #(.WIDTH(4), .IDXW(2), .LOCK_CNT(3), .ERRW(8), .HOLD_OK(1'b1))
    d1 (.clk(clk), .override(ovr), .bus(if1));
  ring_code_monitor #(.WIDTH(4), .IDXW(2), .LOCK_CNT(3), .ERRW(2), .HOLD_OK(1'b0))
    d2 (.clk(clk), .override(ovr), .bus(if2));

  int n_chk  = 0;
  int n_fail = 0;

  // Model: "synced" means a reference sample exists; run counts good rotations.
  int  hold_ok [3] = '{0, 1, 0};
  int  err_max [3] = '{255, 255, 3};
  bit  m_sync  [3];
  bit  m_lock  [3];
  int  m_prev  [3];
  int  m_run   [3];
  int  e_idx   [3];
  int  e_iv    [3];
  int  e_oe    [3];
  int  e_se    [3];
  int  e_err   [3];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step(input int k, input bit o, input bit v, input int r);
    int nxt;
    if (o) begin
      m_sync[k] = 0; m_lock[k] = 0; m_prev[k] = 0; m_run[k] = 0;
      e_idx[k] = 0; e_iv[k] = 0; e_oe[k] = 0; e_se[k] = 0; e_err[k] = 0;
      return;
    end
    e_iv[k] = 0; e_oe[k] = 0; e_se[k] = 0;
    if (!v) return;
    if ($countones(r) != 1) begin
      e_oe[k] = 1; m_sync[k] = 0; m_lock[k] = 0;
    end else begin
      e_iv[k]  = 1;
      e_idx[k] = $clog2(r);
      nxt = ((m_prev[k] * 2) % 16) + (m_prev[k] / 8);
      if (!m_sync[k]) begin
        m_sync[k] = 1; m_prev[k] = r; m_run[k] = 0;
      end else if (r == nxt) begin
        m_prev[k] = r;
        if (!m_lock[k]) begin
          m_run[k]++;
          if (m_run[k] == 3) m_lock[k] = 1;
        end
      end else if (!(hold_ok[k] != 0 && r == m_prev[k])) begin
        e_se[k] = 1; m_prev[k] = r; m_run[k] = 0; m_lock[k] = 0;
      end
    end
    if ((e_oe[k] | e_se[k]) != 0 && e_err[k] < err_max[k]) e_err[k]++;
  endtask

  task automatic cmp(input int k, input int idx, input int iv, input int oe,
                     input int se, input int lk, input int ec);
    string p;
    p = $sformatf("d%0d_", k);
    chk({p, "index"}, idx, e_idx[k]);
    chk({p, "index_valid"}, iv, e_iv[k]);
    chk({p, "onehot_err"}, oe, e_oe[k]);
    chk({p, "seq_err"}, se, e_se[k]);
    chk({p, "locked"}, lk, int'(m_lock[k]));
    chk({p, "err_count"}, ec, e_err[k]);
  endtask

  task automatic cycle(input bit o, input bit v, input logic [3:0] r);
    ovr = o; vld = v; rin = r;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k, o, v, int'(r));
    #1;
    cmp(0, int'(if0.index), int'(if0.index_valid), int'(if0.onehot_err),
        int'(if0.seq_err), int'(if0.locked), int'(if0.err_count));
    cmp(1, int'(if1.index), int'(if1.index_valid), int'(if1.onehot_err),
        int'(if1.seq_err), int'(if1.locked), int'(if1.err_count));
    cmp(2, int'(if2.index), int'(if2.index_valid), int'(if2.onehot_err),
        int'(if2.seq_err), int'(if2.locked), int'(if2.err_count));
  endtask

  initial begin
    logic [3:0] seq1 [5];
    logic [3:0] last;
    int         sel;
    seq1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset: all outputs zero.
    cycle(1'b1, 1'b0, 4'b0000);
    cycle(1'b1, 1'b1, 4'b0100);
    chk("reset_locked", int'(if0.locked), 0);
    chk("reset_err", int'(if0.err_count), 0);

    // Clean rotation: lock after the 4th sample, wrap is legal.
    foreach (seq1[i]) begin
      cycle(1'b0, 1'b1, seq1[i]);
      chk("t1_index", int'(if0.index), i % 4);
      chk("t1_locked", int'(if0.locked), (i >= 3) ? 1 : 0);
    end
    chk("t1_err", int'(if0.err_count), 0);

    // Wrong rotation while locked, then reacquire.
    cycle(1'b0, 1'b1, 4'b0100);
    chk("t2_seq_err", int'(if0.seq_err), 1);
    chk("t2_locked", int'(if0.locked), 0);
    chk("t2_err", int'(if0.err_count), 1);
    cycle(1'b0, 1'b1, 4'b1000);
    cycle(1'b0, 1'b1, 4'b0001);
    cycle(1'b0, 1'b1, 4'b0010);
    chk("t2_relock", int'(if0.locked), 1);

    // Gap of invalid cycles while locked, then the correct successor.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 4'b1111);
    chk("t4_locked", int'(if0.locked), 1);
    chk("t4_index", int'(if0.index), 1);
    cycle(1'b0, 1'b1, 4'b0100);
    chk("t4_resume", int'(if0.seq_err), 0);

    // Illegal codes: zero and two-hot.
    cycle(1'b0, 1'b1, 4'b0000);
    cycle(1'b0, 1'b1, 4'b0110);
    chk("t3_onehot_err", int'(if0.onehot_err), 1);
    chk("t3_index_hold", int'(if0.index), 2);
    chk("t3_err", int'(if0.err_count), 3);

    // Repeated sample: accepted only with HOLD_OK=1.
    cycle(1'b1, 1'b0, 4'b0000);
    cycle(1'b0, 1'b1, 4'b0010);
    cycle(1'b0, 1'b1, 4'b0010);
    cycle(1'b0, 1'b1, 4'b0100);
    chk("t5_hold0_err", int'(if0.err_count), 1);
    chk("t5_hold1_err", int'(if1.err_count), 0);

    // Override mid-lock with a valid sample present.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 4'b0001 << ((i + 3) % 4));
    chk("t6_prelock", int'(if0.locked), 1);
    cycle(1'b1, 1'b1, 4'b0001);
    chk("t6_ovr_locked", int'(if0.locked), 0);
    chk("t6_ovr_index", int'(if0.index), 0);

    // Saturation on the narrow counter.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 4'b0000);
    chk("t6_sat2", int'(if2.err_count), 3);
    chk("t6_sat8", int'(if0.err_count), 5);

    // Randomized stream biased toward valid rotations.
    last = 4'b0001;
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 2) begin
        cycle(1'b1, $urandom_range(0, 1) != 0, 4'($urandom_range(0, 15)));
        last = 4'b0001;
      end else if (sel < 12) begin
        cycle(1'b0, 1'b0, 4'($urandom_range(0, 15)));
      end else if (sel < 65) begin
        last = {last[2:0], last[3]};
        cycle(1'b0, 1'b1, last);
      end else if (sel < 75) begin
        cycle(1'b0, 1'b1, last);
      end else if (sel < 90) begin
        last = 4'b0001 << $urandom_range(0, 3);
        cycle(1'b0, 1'b1, last);
      end else begin
        cycle(1'b0, 1'b1, 4'($urandom_range(0, 15)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
